// File: rtl/gtp_pkg.sv
// Shared GTP sequencer definitions: FSM state encoding used by the PLL and channel controllers.
package gtp_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        OFF       = 3'd0,
        PWRUP     = 3'd1,
        RESET     = 3'd2,
        WAIT_LOCK = 3'd3,
        LOCKED    = 3'd4,
        FAULT     = 3'd5
    } pll_state_t;

endpackage

// File: rtl/gtp_sync2.sv
// Two-flop synchroniser for asynchronous status inputs from the GTPE2_COMMON.
module gtp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], d};
        end
    end

    assign q = sync_ff[1];

endmodule

// File: rtl/gtp_common_pll_ctrl.sv
// Power-up / reset / lock sequencer for one GTPE2_COMMON PLL.
// Define GTP_PLL_AUTO_RELOCK_EN to re-run the reset sequence on lock loss instead of faulting.
module gtp_common_pll_ctrl
    import gtp_pkg::*;
#(
    parameter int PD_WAIT_CYCLES = 500,
    parameter int RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pll_lock,
    input  logic         refclk_lost,
    output logic         pll_pd,
    output logic         pll_reset,
    output logic         pll_locken,
    output logic         ready,
    output logic         fault,
    output logic [1:0]   retry_cnt,
    output logic [2:0]   state_o
);

    localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

    pll_state_t       state, next_state;
    logic [CNT_W-1:0] timer, timer_next;
    logic [CNT_W-1:0] stable, stable_next;
    logic [1:0]       retry_next;
    logic             lock_s, lost_s;

    gtp_sync2 u_lock_sync (.clk(clk), .rst(rst), .d(pll_lock),    .q(lock_s));
    gtp_sync2 u_lost_sync (.clk(clk), .rst(rst), .d(refclk_lost), .q(lost_s));

    always_comb begin
        next_state  = state;
        timer_next  = timer + CNT_W'(1);
        stable_next = '0;
        retry_next  = retry_cnt;
        case (state)
            OFF: begin
                timer_next = '0;
                retry_next = '0;
                if (start) next_state = PWRUP;
            end
            PWRUP: begin
                if (timer == PD_LAST) begin
                    next_state = RESET;
                    timer_next = '0;
                end
            end
            RESET: begin
                if (timer == RESET_LAST) begin
                    next_state = WAIT_LOCK;
                    timer_next = '0;
                end
            end
            WAIT_LOCK: begin
                stable_next = lock_s ? stable + CNT_W'(1) : '0;
                // A lock completing on the timeout cycle still counts as locked.
                if (lock_s && (stable == STABLE_LAST)) begin
                    next_state  = LOCKED;
                    timer_next  = '0;
                    stable_next = '0;
                end else if (timer == TO_LAST) begin
                    timer_next  = '0;
                    stable_next = '0;
                    if (retry_cnt < RETRY_MAX) begin
                        next_state = RESET;
                        retry_next = retry_cnt + 2'd1;
                    end else begin
                        next_state = FAULT;
                    end
                end
            end
            LOCKED: begin
                timer_next = '0;
                if (!lock_s || lost_s) begin
`ifdef GTP_PLL_AUTO_RELOCK_EN
                    next_state = RESET;
                    retry_next = '0;
`else
                    next_state = FAULT;
`endif
                end
            end
            FAULT: begin
                timer_next = '0;
            end
            default: begin
                next_state = OFF;
                timer_next = '0;
            end
        endcase
        // Dropping start powers the PLL down from anywhere, even mid reset pulse.
        if (!start) begin
            next_state  = OFF;
            timer_next  = '0;
            stable_next = '0;
            retry_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            timer      <= '0;
            stable     <= '0;
            retry_cnt  <= '0;
            pll_pd     <= 1'b1;
            pll_reset  <= 1'b0;
            pll_locken <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= next_state;
            timer      <= timer_next;
            stable     <= stable_next;
            retry_cnt  <= retry_next;
            pll_pd     <= (next_state == OFF);
            pll_reset  <= (next_state == RESET);
            pll_locken <= (next_state != OFF);
            ready      <= (next_state == LOCKED);
            fault      <= (next_state == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_gtp_common_pll_ctrl.sv
// Self-checking bench for gtp_common_pll_ctrl: directed scenarios plus random lock profiles
// compared against a window-based reference model.
module tb_gtp_common_pll_ctrl;

    localparam int PD_WAIT = 8;
    localparam int RST_W   = 4;
    localparam int TIMEOUT = 100;
    localparam int STABLE  = 10;
    localparam int MAXR    = 2;
    localparam int N       = 400;

    // Output vector per phase: {pll_pd, pll_reset, pll_locken, ready, fault}
    localparam logic [4:0] PH_PWRUP  = 5'b00100;
    localparam logic [4:0] PH_RESET  = 5'b01100;
    localparam logic [4:0] PH_WAIT   = 5'b00100;
    localparam logic [4:0] PH_LOCKED = 5'b00110;
    localparam logic [4:0] PH_FAULT  = 5'b00101;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pll_lock;
    logic       refclk_lost;
    logic       pll_pd;
    logic       pll_reset;
    logic       pll_locken;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    bit         lock_arr [N];
    logic [6:0] obs_arr  [N];
    logic [6:0] exp_arr  [N];

    always #5 clk = ~clk;

    gtp_common_pll_ctrl #(
        .PD_WAIT_CYCLES(PD_WAIT),
        .RESET_CYCLES  (RST_W),
        .LOCK_TIMEOUT  (TIMEOUT),
        .LOCK_STABLE   (STABLE),
        .MAX_RETRIES   (MAXR),
        .CNT_W         (17)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pll_lock   (pll_lock),
        .refclk_lost(refclk_lost),
        .pll_pd     (pll_pd),
        .pll_reset  (pll_reset),
        .pll_locken (pll_locken),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state_o    (state_o)
    );

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; pll_lock = 1'b0; refclk_lost = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Holds start high and plays lock_arr, one entry per clock, recording outputs after each edge.
    task automatic apply_stimulus();
        for (int k = 0; k < N; k++) begin
            start    = 1'b1;
            pll_lock = lock_arr[k];
            @(posedge clk);
            @(negedge clk);
            obs_arr[k] = {pll_pd, pll_reset, pll_locken, ready, fault, retry_cnt};
        end
    endtask

    // Lock level the controller acts on at edge e (two-flop synchroniser delay).
    function automatic bit lk(int e);
        return (e >= 2) ? lock_arr[e-2] : 1'b0;
    endfunction

    function automatic void fill(int from, int upto, logic [4:0] ph, int r);
        for (int k = from; k < upto && k < N; k++) exp_arr[k] = {ph, 2'(r)};
    endfunction

    // Expected trace derived from phase durations and lock windows.
    function automatic void build_model();
        int t, w, run, lock_at, loss, r;
        r = 0;
        fill(0, PD_WAIT + 1, PH_PWRUP, 0);
        t = PD_WAIT + 1;
        while (t < N) begin
            fill(t, t + RST_W, PH_RESET, r);
            w = t + RST_W;
            run = 0;
            lock_at = -1;
            for (int e = w + 1; e <= w + TIMEOUT; e++) begin
                run = lk(e) ? run + 1 : 0;
                if (run == STABLE) begin
                    lock_at = e;
                    break;
                end
            end
            if (lock_at >= 0) begin
                fill(w, lock_at, PH_WAIT, r);
                loss = -1;
                for (int e = lock_at + 1; e < N; e++) begin
                    if (!lk(e)) begin
                        loss = e;
                        break;
                    end
                end
                if (loss < 0) begin
                    fill(lock_at, N, PH_LOCKED, r);
                    t = N;
                end else begin
                    fill(lock_at, loss, PH_LOCKED, r);
`ifdef GTP_PLL_AUTO_RELOCK_EN
                    r = 0;
                    t = loss;
`else
                    fill(loss, N, PH_FAULT, r);
                    t = N;
`endif
                end
            end else begin
                fill(w, w + TIMEOUT, PH_WAIT, r);
                if (r < MAXR) begin
                    r++;
                    t = w + TIMEOUT;
                end else begin
                    fill(w + TIMEOUT, N, PH_FAULT, r);
                    t = N;
                end
            end
        end
    endfunction

    task automatic check_trace(input string name);
        int bad;
        build_model();
        bad = 0;
        for (int k = 0; k < N; k++) begin
            checks++;
            assert (obs_arr[k] === exp_arr[k]) else begin
                errors++;
                bad++;
                if (bad <= 20)
                    $error("[TB] FAIL %s cycle %0d observed=%b expected=%b", name, k, obs_arr[k], exp_arr[k]);
            end
        end
    endtask

    function automatic int count_rises(int b);
        int c = 0;
        for (int k = 0; k < N; k++)
            if (obs_arr[k][b] && (k == 0 || !obs_arr[k-1][b])) c++;
        return c;
    endfunction

    function automatic int nth_rise(int b, int n);
        int c = 0;
        for (int k = 0; k < N; k++) begin
            if (obs_arr[k][b] && (k == 0 || !obs_arr[k-1][b])) begin
                if (c == n) return k;
                c++;
            end
        end
        return -1;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; pll_lock = 1'b0; refclk_lost = 1'b0;

        // Reset values
        #1;
        check_output("rst_outputs", 16'({pll_pd, pll_reset, pll_locken, ready, fault, retry_cnt}), 16'b1000000);
        check_output("rst_state", 16'(state_o), 16'd0);
        do_reset();

        // Bring-up with lock from cycle 20
        for (int k = 0; k < N; k++) lock_arr[k] = (k >= 20);
        apply_stimulus();
        check_trace("bringup");
        check_output("bringup_pd_fall", 16'(obs_arr[0][6]), 16'd0);
        check_output("bringup_reset_rise", 16'(nth_rise(5, 0)), 16'd9);
        check_output("bringup_reset_width", 16'(obs_arr[12][5] && !obs_arr[13][5] && obs_arr[9][5]), 16'd1);
        check_output("bringup_ready_at", 16'(nth_rise(3, 0)), 16'd31);
        check_output("bringup_final", 16'({ready, retry_cnt}), 16'b100);

        // Lock never arrives: retries then fault
        do_reset();
        for (int k = 0; k < N; k++) lock_arr[k] = 1'b0;
        apply_stimulus();
        check_trace("timeout");
        check_output("timeout_pulses", 16'(count_rises(5)), 16'd3);
        check_output("timeout_rise2", 16'(nth_rise(5, 1)), 16'd113);
        check_output("timeout_rise3", 16'(nth_rise(5, 2)), 16'd217);
        check_output("timeout_final", 16'({fault, ready, retry_cnt}), 16'b1010);
        check_output("timeout_state", 16'(state_o), 16'd5);

        // Lock toggling every 5 cycles never qualifies
        do_reset();
        for (int k = 0; k < N; k++) lock_arr[k] = ((k / 5) % 2) == 1;
        apply_stimulus();
        check_trace("unstable");
        check_output("unstable_no_ready", 16'(count_rises(3)), 16'd0);
        check_output("unstable_fault", 16'(fault), 16'd1);

        // One-cycle lock drop while locked
        do_reset();
        for (int k = 0; k < N; k++) lock_arr[k] = (k >= 20) && (k != 60);
        apply_stimulus();
        check_trace("lockloss");
`ifdef GTP_PLL_AUTO_RELOCK_EN
        check_output("lockloss_pulses", 16'(count_rises(5)), 16'd2);
        check_output("lockloss_relock_at", 16'(nth_rise(3, 1)), 16'd76);
        check_output("lockloss_final", 16'({ready, fault}), 16'b10);
`else
        check_output("lockloss_pulses", 16'(count_rises(5)), 16'd1);
        check_output("lockloss_final", 16'({ready, fault, pll_reset}), 16'b010);
`endif

        // Abort during the second cycle of the reset pulse
        do_reset();
        pll_lock = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check_output("abort_in_reset", 16'(pll_reset), 16'd1);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_outputs", 16'({pll_reset, pll_pd, fault, retry_cnt}), 16'b01000);
        check_output("abort_state", 16'(state_o), 16'd0);
        for (int k = 0; k < N; k++) lock_arr[k] = (k >= 20);
        apply_stimulus();
        check_trace("restart");

        // Asynchronous reset while locked, between clock edges
        #2 rst = 1'b1;
        #1;
        check_output("async_rst", 16'({ready, pll_pd, pll_locken, pll_reset}), 16'b0100);
        check_output("async_rst_state", 16'(state_o), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reference clock loss while locked
        do_reset();
        for (int k = 0; k < N; k++) lock_arr[k] = 1'b1;
        apply_stimulus();
        check_trace("lost_prelock");
        refclk_lost = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef GTP_PLL_AUTO_RELOCK_EN
        check_output("refclk_lost", 16'({ready, fault, pll_reset, retry_cnt}), 16'b00100);
`else
        check_output("refclk_lost", 16'({ready, fault, pll_reset}), 16'b010);
`endif
        refclk_lost = 1'b0;

        // Random lock profiles built from alternating runs
        for (int trial = 0; trial < 6; trial++) begin
            int k;
            bit v;
            do_reset();
            k = 0;
            v = 1'b0;
            while (k < N) begin
                int len;
                len = v ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 60));
                for (int j = 0; j < len && k < N; j++) begin
                    lock_arr[k] = v;
                    k++;
                end
                v = ~v;
            end
            apply_stimulus();
            check_trace($sformatf("random%0d", trial));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
